// File: rtl/ecc_point_seq_pkg.sv
// rtl/ecc_point_seq_pkg.sv - shared types and constants for the EC point sequencer
package ecc_pkg;

  // GF arithmetic unit opcodes
  localparam logic [1:0] GF_ADD = 2'd0;
  localparam logic [1:0] GF_SUB = 2'd1;
  localparam logic [1:0] GF_MUL = 2'd2;
  localparam logic [1:0] GF_DIV = 2'd3;

  // Register file indices
  localparam logic [3:0] X1 = 4'd0;
  localparam logic [3:0] Y1 = 4'd1;
  localparam logic [3:0] X2 = 4'd2;
  localparam logic [3:0] Y2 = 4'd3;
  localparam logic [3:0] A  = 4'd4;
  localparam logic [3:0] L  = 4'd5;
  localparam logic [3:0] T  = 4'd6;
  localparam logic [3:0] U  = 4'd7;
  localparam logic [3:0] X3 = 4'd8;
  localparam logic [3:0] Y3 = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } state_t;

  typedef enum logic {
    SEQ_ADD,
    SEQ_DBL
  } seq_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst;
    logic       last;
  } ustep_t;

  function automatic ustep_t mk_step(input logic [1:0] op, input logic [3:0] src_a,
                                     input logic [3:0] src_b, input logic [3:0] dst,
                                     input logic last);
    ustep_t s;
    s.op    = op;
    s.src_a = src_a;
    s.src_b = src_b;
    s.dst   = dst;
    s.last  = last;
    return s;
  endfunction

endpackage

// File: rtl/ecc_point_seq_if.sv
// rtl/ecc_point_seq_if.sv - request/response bus to the shared GF arithmetic unit
interface ecc_point_seq_if #(
  parameter int SIZE = 32
) ();
  logic [SIZE-1:0] gf_in_0;
  logic [SIZE-1:0] gf_in_1;
  logic [1:0]      gf_op;
  logic            gf_issue;
  logic [SIZE-1:0] gf_prime;
  logic [SIZE-1:0] gf_result;
  logic            gf_done;

  modport master (
    output gf_in_0, gf_in_1, gf_op, gf_issue, gf_prime,
    input  gf_result, gf_done
  );

  modport slave (
    input  gf_in_0, gf_in_1, gf_op, gf_issue, gf_prime,
    output gf_result, gf_done
  );
endinterface

// File: rtl/ecc_point_seq_ucode_rom.sv
// rtl/ecc_point_seq_ucode_rom.sv - microstep table for point add and point double
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  seq_t       seq_sel,
  input  logic [3:0] step,
  output ustep_t     ustep
);

  // Table lookup; T/U are scratch, L holds lambda across the sequence
  always_comb begin
    ustep = '0;
    case (seq_sel)
      SEQ_ADD: begin
        case (step)
          4'd0:    ustep = mk_step(GF_SUB, Y2, Y1, T,  1'b0);
          4'd1:    ustep = mk_step(GF_SUB, X2, X1, U,  1'b0);
          4'd2:    ustep = mk_step(GF_DIV, T,  U,  L,  1'b0);
          4'd3:    ustep = mk_step(GF_MUL, L,  L,  T,  1'b0);
          4'd4:    ustep = mk_step(GF_SUB, T,  X1, T,  1'b0);
          4'd5:    ustep = mk_step(GF_SUB, T,  X2, X3, 1'b0);
          4'd6:    ustep = mk_step(GF_SUB, X1, X3, T,  1'b0);
          4'd7:    ustep = mk_step(GF_MUL, L,  T,  T,  1'b0);
          4'd8:    ustep = mk_step(GF_SUB, T,  Y1, Y3, 1'b1);
          default: ustep = '0;
        endcase
      end
      SEQ_DBL: begin
        case (step)
          4'd0:    ustep = mk_step(GF_MUL, X1, X1, T,  1'b0);
          4'd1:    ustep = mk_step(GF_ADD, T,  T,  U,  1'b0);
          4'd2:    ustep = mk_step(GF_ADD, U,  T,  T,  1'b0);
          4'd3:    ustep = mk_step(GF_ADD, T,  A,  T,  1'b0);
          4'd4:    ustep = mk_step(GF_ADD, Y1, Y1, U,  1'b0);
          4'd5:    ustep = mk_step(GF_DIV, T,  U,  L,  1'b0);
          4'd6:    ustep = mk_step(GF_MUL, L,  L,  T,  1'b0);
          4'd7:    ustep = mk_step(GF_ADD, X1, X1, U,  1'b0);
          4'd8:    ustep = mk_step(GF_SUB, T,  U,  X3, 1'b0);
          4'd9:    ustep = mk_step(GF_SUB, X1, X3, T,  1'b0);
          4'd10:   ustep = mk_step(GF_MUL, L,  T,  T,  1'b0);
          4'd11:   ustep = mk_step(GF_SUB, T,  Y1, Y3, 1'b1);
          default: ustep = '0;
        endcase
      end
      default: ustep = '0;
    endcase
  end

endmodule

// File: rtl/ecc_point_seq.sv
// rtl/ecc_point_seq.sv - affine EC point add/double sequencer driving a GF arithmetic unit
module ecc_point_seq
  import ecc_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            op,
  input  logic [SIZE-1:0] x1,
  input  logic [SIZE-1:0] y1,
  input  logic [SIZE-1:0] x2,
  input  logic [SIZE-1:0] y2,
  input  logic [SIZE-1:0] curve_a,
  input  logic [SIZE-1:0] prime,
  ecc_point_seq_if.master gf,
  output logic            busy,
  output logic            done,
  output logic            inf,
  output logic            err,
  output logic [SIZE-1:0] x3,
  output logic [SIZE-1:0] y3
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  seq_t              seq_q;
  logic [3:0]        step_q;
  logic              op_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [SIZE-1:0]   rf [16];
  logic              inf_q, err_q;
  logic [SIZE-1:0]   x3_q, y3_q;
  ustep_t            us;

  logic same_x, same_y, dbl_sel, chk_inf, tmo_hit;

  ecc_ucode_rom u_rom (
    .seq_sel (seq_q),
    .step    (step_q),
    .ustep   (us)
  );

  // Doubling a point onto itself, or adding its negation, is decided before any GF traffic
  assign same_x  = (rf[X1] == rf[X2]);
  assign same_y  = (rf[Y1] == rf[Y2]);
  assign dbl_sel = op_q | (same_x & same_y);
  assign chk_inf = dbl_sel ? (rf[Y1] == '0) : same_x;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  assign gf.gf_prime = prime;
  assign inf = inf_q;
  assign err = err_q;
  assign x3  = x3_q;
  assign y3  = y3_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; operands stay driven through WAIT
  always_comb begin
    state_nx      = state;
    busy          = 1'b0;
    done          = 1'b0;
    gf.gf_issue   = 1'b0;
    gf.gf_op      = GF_ADD;
    gf.gf_in_0    = '0;
    gf.gf_in_1    = '0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        busy     = 1'b1;
        state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        busy     = 1'b1;
        state_nx = chk_inf ? ST_FIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy        = 1'b1;
        gf.gf_issue = 1'b1;
        gf.gf_op    = us.op;
        gf.gf_in_0  = rf[us.src_a];
        gf.gf_in_1  = rf[us.src_b];
        state_nx    = ST_WAIT;
      end
      ST_WAIT: begin
        busy       = 1'b1;
        gf.gf_op   = us.op;
        gf.gf_in_0 = rf[us.src_a];
        gf.gf_in_1 = rf[us.src_b];
        if (gf.gf_done) state_nx = us.last ? ST_FIN : ST_ISSUE;
        else if (tmo_hit) state_nx = ST_FIN;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Register file, microstep pointer, timeout counter and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      seq_q   <= SEQ_ADD;
      step_q  <= '0;
      op_q    <= 1'b0;
      tmo_cnt <= '0;
      inf_q   <= 1'b0;
      err_q   <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rf[X1] <= x1;
            rf[Y1] <= y1;
            rf[X2] <= x2;
            rf[Y2] <= y2;
            rf[A]  <= curve_a;
            op_q   <= op;
            inf_q  <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          rf[L]  <= '0;
          rf[T]  <= '0;
          rf[U]  <= '0;
          rf[X3] <= '0;
          rf[Y3] <= '0;
        end
        ST_CHECK: begin
          seq_q  <= dbl_sel ? SEQ_DBL : SEQ_ADD;
          step_q <= '0;
          if (chk_inf) begin
            inf_q <= 1'b1;
            x3_q  <= '0;
            y3_q  <= '0;
          end
        end
        ST_ISSUE: tmo_cnt <= '0;
        ST_WAIT: begin
          if (gf.gf_done) begin
            rf[us.dst] <= gf.gf_result;
            step_q     <= step_q + 4'd1;
            if (us.last) begin
              x3_q <= (us.dst == X3) ? gf.gf_result : rf[X3];
              y3_q <= (us.dst == Y3) ? gf.gf_result : rf[Y3];
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
